// File: rtl/led_pattern_gen_if.sv
// Pattern-control and LED-output bundle for led_pattern_gen.
// The master drives mode/hold/load; the slave (the generator) drives the LED pattern and strobes.
interface led_pattern_gen_if #(
    parameter int WIDTH = 10
);
    logic [1:0]       mode;
    logic             hold;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] runled;
    logic             step;
    logic             wrap;

    modport master (
        output mode, hold, load, load_value,
        input  runled, step, wrap
    );

    modport slave (
        input  mode, hold, load, load_value,
        output runled, step, wrap
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Prescaled LED activity driver with up-count, down-count, bounce-scan and blink patterns,
// plus hold, synchronous preload, and registered step/wrap strobes.
module led_pattern_gen #(
    parameter int          WIDTH      = 10,
    parameter logic [19:0] DECIMATION = 20'd16
) (
    input logic              clk,
    input logic              reset,
    led_pattern_gen_if.slave bus
);
    // mode | meaning
    // UP   | runled counts up, wraps all-ones -> 0
    // DOWN | runled counts down, wraps 0 -> all-ones
    // SCAN | single lit LED bounces between LSB and MSB
    // BLINK| runled toggles between 0 and all-ones
    typedef enum logic [1:0] {
        MODE_UP    = 2'b00,
        MODE_DOWN  = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [19:0]      PCNT_LAST = DECIMATION - 20'd1;

    logic [19:0]      pcnt_q, pcnt_d;
    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] runled_q, runled_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    mode_e            mode_in;

    assign mode_in = mode_e'(bus.mode);

    always_comb begin
        tick     = (pcnt_q == PCNT_LAST) && !bus.hold;
        pcnt_d   = pcnt_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        runled_d = runled_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;

        if (bus.load) begin
            runled_d = bus.load_value;
            pcnt_d   = '0;
            dir_d    = 1'b0;
            mode_d   = mode_in;
        end else if (mode_in != mode_q) begin
            // A mode change reseeds the pattern even while held
            mode_d = mode_in;
            pcnt_d = '0;
            dir_d  = 1'b0;
            case (mode_in)
                MODE_UP:   runled_d = '0;
                MODE_DOWN: runled_d = ALL_ONES;
                MODE_SCAN: runled_d = ONE;
                default:   runled_d = '0;
            endcase
        end else if (!bus.hold) begin
            pcnt_d = tick ? 20'd0 : pcnt_q + 20'd1;
            if (tick) begin
                step_d = 1'b1;
                case (mode_q)
                    MODE_UP: begin
                        runled_d = runled_q + ONE;
                        wrap_d   = (runled_q == ALL_ONES);
                    end
                    MODE_DOWN: begin
                        runled_d = runled_q - ONE;
                        wrap_d   = (runled_q == '0);
                    end
                    MODE_SCAN: begin
                        if (WIDTH == 1) begin
                            runled_d = ONE;
                            dir_d    = 1'b0;
                            wrap_d   = 1'b1;
                        end else if (runled_q == '0) begin
                            runled_d = ONE;
                            dir_d    = 1'b0;
                        end else if (!dir_q) begin
                            if (runled_q[WIDTH-1]) begin
                                runled_d = runled_q >> 1;
                                dir_d    = 1'b1;
                            end else begin
                                runled_d = runled_q << 1;
                            end
                        end else if (runled_q[0]) begin
                            // Reversal at the LSB closes one scan period
                            runled_d = runled_q << 1;
                            dir_d    = 1'b0;
                            wrap_d   = 1'b1;
                        end else begin
                            runled_d = runled_q >> 1;
                        end
                    end
                    default: begin
                        if (runled_q == '0) begin
                            runled_d = ALL_ONES;
                            wrap_d   = 1'b1;
                        end else begin
                            runled_d = '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q   <= '0;
            mode_q   <= MODE_UP;
            dir_q    <= 1'b0;
            runled_q <= '0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            runled_q <= runled_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.runled = runled_q;
    assign bus.step   = step_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a 4-bit/decimate-3 instance and a 10-bit/decimate-1 instance,
// each compared every cycle against a behavioural model, plus directed pattern checks.
module tb_led_pattern_gen;
    localparam int          WA = 4;
    localparam logic [19:0] DA = 20'd3;
    localparam int          WB = 10;
    localparam logic [19:0] DB = 20'd1;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    led_pattern_gen_if #(.WIDTH(WA)) bus_a ();
    led_pattern_gen_if #(.WIDTH(WB)) bus_b ();

    led_pattern_gen #(.WIDTH(WA), .DECIMATION(DA)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    led_pattern_gen #(.WIDTH(WB), .DECIMATION(DB)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint led;
        int     pc;
        int     mode;
        bit     dir;
        bit     step;
        bit     wrap;
    } mdl_t;

    mdl_t   ma;
    mdl_t   mb;
    longint exp_scan [7] = '{2, 4, 8, 4, 2, 1, 2};

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.led = 0; r.pc = 0; r.mode = 0; r.dir = 0; r.step = 0; r.wrap = 0;
        return r;
    endfunction

    // One clock edge of the pattern rules, using plain integer arithmetic.
    function automatic mdl_t mdl_next(mdl_t s, int w, int dec, int mode, bit hold, bit load, longint lv);
        mdl_t   r = s;
        longint span = longint'(1) << w;
        longint full = span - 1;
        longint msb  = longint'(1) << (w - 1);
        r.step = 0;
        r.wrap = 0;
        if (load) begin
            r.led = lv; r.pc = 0; r.dir = 0; r.mode = mode;
            return r;
        end
        if (mode != s.mode) begin
            r.mode = mode; r.pc = 0; r.dir = 0;
            r.led  = (mode == 1) ? full : (mode == 2) ? 1 : 0;
            return r;
        end
        if (hold) return r;
        if (s.pc != dec - 1) begin
            r.pc = s.pc + 1;
            return r;
        end
        r.pc   = 0;
        r.step = 1;
        case (s.mode)
            0: begin r.led = (s.led + 1) % span; r.wrap = (s.led == full); end
            1: begin r.led = (s.led + full) % span; r.wrap = (s.led == 0); end
            2: begin
                if (w == 1) begin r.led = 1; r.dir = 0; r.wrap = 1; end
                else if (s.led == 0) begin r.led = 1; r.dir = 0; end
                else if (!s.dir) begin
                    if (s.led >= msb) begin r.led = s.led / 2; r.dir = 1; end
                    else r.led = (s.led * 2) % span;
                end else if (s.led % 2 == 1) begin
                    r.led = (s.led * 2) % span; r.dir = 0; r.wrap = 1;
                end else r.led = s.led / 2;
            end
            default: begin
                if (s.led == 0) begin r.led = full; r.wrap = 1; end
                else r.led = 0;
            end
        endcase
        return r;
    endfunction

    task automatic drive_a(input int mode, input bit hold, input bit load, input longint lv);
        bus_a.mode       = 2'(mode);
        bus_a.hold       = hold;
        bus_a.load       = load;
        bus_a.load_value = lv[WA-1:0];
    endtask

    task automatic drive_b(input int mode, input bit hold, input bit load, input longint lv);
        bus_b.mode       = 2'(mode);
        bus_b.hold       = hold;
        bus_b.load       = load;
        bus_b.load_value = lv[WB-1:0];
    endtask

    task automatic cyc_a(input string tag);
        @(posedge clk);
        if (rst_a) ma = mdl_reset();
        else ma = mdl_next(ma, WA, int'(DA), int'(bus_a.mode), bus_a.hold, bus_a.load,
                           longint'(bus_a.load_value));
        #1;
        chk({tag, "_led"},  longint'(bus_a.runled), ma.led);
        chk({tag, "_step"}, longint'(bus_a.step),   longint'(ma.step));
        chk({tag, "_wrap"}, longint'(bus_a.wrap),   longint'(ma.wrap));
    endtask

    task automatic cyc_b(input string tag);
        @(posedge clk);
        if (rst_b) mb = mdl_reset();
        else mb = mdl_next(mb, WB, int'(DB), int'(bus_b.mode), bus_b.hold, bus_b.load,
                           longint'(bus_b.load_value));
        #1;
        chk({tag, "_led"},  longint'(bus_b.runled), mb.led);
        chk({tag, "_step"}, longint'(bus_b.step),   longint'(mb.step));
        chk({tag, "_wrap"}, longint'(bus_b.wrap),   longint'(mb.wrap));
    endtask

    initial begin
        int     wraps;
        int     steps;
        int     cnt;
        int     m;
        longint seen [$];
        bit     wq [$];

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        ma = mdl_reset();
        mb = mdl_reset();
        cyc_a("rst");
        cyc_b("rst_b");
        rst_a = 1'b0;

        wraps = 0;
        steps = 0;
        for (int i = 0; i < 48; i++) begin
            cyc_a("up");
            wraps += int'(bus_a.wrap);
            steps += int'(bus_a.step);
        end
        chk("up_steps", steps, 16);
        chk("up_wraps", wraps, 1);
        chk("up_end", longint'(bus_a.runled), 0);

        drive_a(2, 0, 0, 0);
        cyc_a("scan_seed");
        chk("scan_seed_val", longint'(bus_a.runled), 1);
        for (int i = 0; i < 21; i++) begin
            cyc_a("scan");
            if (bus_a.step) begin
                seen.push_back(longint'(bus_a.runled));
                wq.push_back(bus_a.wrap);
            end
        end
        chk("scan_nsteps", seen.size(), 7);
        for (int i = 0; i < 7 && i < seen.size(); i++) begin
            chk($sformatf("scan_v%0d", i), seen[i], exp_scan[i]);
            chk($sformatf("scan_w%0d", i), longint'(wq[i]), (i == 6) ? 1 : 0);
        end

        drive_a(2, 0, 1, 0);
        cyc_a("ld0");
        drive_a(2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc_a("ld0_run");
        chk("ld0_tick", longint'(bus_a.runled), 1);

        drive_a(0, 0, 1, 5);
        cyc_a("ld5");
        drive_a(3, 0, 0, 0);
        cyc_a("blk_mc");
        chk("blk_first", longint'(bus_a.runled), 0);
        for (int i = 0; i < 3; i++) cyc_a("blk");
        chk("blk_on", longint'(bus_a.runled), 15);
        chk("blk_on_wrap", longint'(bus_a.wrap), 1);
        for (int i = 0; i < 3; i++) cyc_a("blk");
        chk("blk_off", longint'(bus_a.runled), 0);
        drive_a(1, 0, 0, 0);
        cyc_a("dn_mc");
        chk("dn_seed", longint'(bus_a.runled), 15);
        for (int i = 0; i < 3; i++) cyc_a("dn");
        chk("dn_step", longint'(bus_a.runled), 14);

        cyc_a("pre_hold");
        drive_a(1, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc_a("hold");
        chk("hold_frz", longint'(bus_a.runled), 14);
        drive_a(1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc_a("post_hold");
            cnt++;
            if (bus_a.step) break;
        end
        chk("hold_delay", 1 + 7 + cnt, 10);
        chk("hold_val", longint'(bus_a.runled), 13);

        for (int i = 0; i < 400; i++) begin
            m = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : int'(bus_a.mode);
            drive_a(m, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, longint'($urandom));
            cyc_a("rnd_a");
        end

        drive_a(1, 0, 1, 9);
        cyc_a("pre_rst");
        drive_a(0, 0, 0, 0);
        #2;
        rst_a = 1'b1;
        #1;
        ma = mdl_reset();
        chk("arst_led",  longint'(bus_a.runled), 0);
        chk("arst_step", longint'(bus_a.step), 0);
        chk("arst_wrap", longint'(bus_a.wrap), 0);
        cyc_a("arst_hold");
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) cyc_a("restart");
        chk("restart_val", longint'(bus_a.runled), 1);
        chk("restart_step", longint'(bus_a.step), 1);

        rst_a = 1'b1;
        rst_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_b("b_up");
            cnt += int'(bus_b.step);
        end
        chk("b_steps", cnt, 20);
        chk("b_val", longint'(bus_b.runled), 20);

        drive_b(2, 1, 1, 'h2A);
        cyc_b("b_ld");
        chk("b_ld_val", longint'(bus_b.runled), 'h2A);
        chk("b_ld_step", longint'(bus_b.step), 0);
        drive_b(2, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            m = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : int'(bus_b.mode);
            drive_b(m, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, longint'($urandom));
            cyc_b("rnd_b");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
